// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// A start/busy/done handshake runs one shift-and-correct iteration per clock and flags bad digits or out-of-range results.
module bcd_to_bin_seq #(
  parameter int NDIGITS = 2,
  parameter int BIN_W   = 7,
  parameter int MAX_VAL = 59
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic [BIN_W-1:0]       bin_out,
  output logic                   digit_err,
  output logic                   range_err
);

  localparam int BCD_W = 4 * NDIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_U = MAX_VAL;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [BIN_W-1:0]    bin_out_q, bin_out_d;
  logic                digit_err_q, digit_err_d;
  logic                range_err_q, range_err_d;
  logic [SR_W-1:0]     step;

  // One iteration: shift {BCD, BIN} right, then pull every digit that became >= 8 back by 3.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
    logic [SR_W-1:0] s;
    logic [3:0]      dig;
    s = v >> 1;
    for (int i = 0; i < NDIGITS; i++) begin
      dig = s[BIN_W + 4*i +: 4];
      if (dig >= 4'd8) begin
        s[BIN_W + 4*i +: 4] = dig - 4'd3;
      end
    end
    return s;
  endfunction

  function automatic logic any_bad_digit(input logic [BCD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  function automatic logic over_limit(input logic [BIN_W-1:0] v);
    return 32'(v) > MAX_U;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bin_out_d   = bin_out_q;
    digit_err_d = digit_err_q;
    range_err_d = range_err_q;
    step        = dabble_step(sr_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d        = {bcd_in, {BIN_W{1'b0}}};
          bin_out_d   = '0;
          digit_err_d = 1'b0;
          range_err_d = 1'b0;
          busy_d      = 1'b1;
          if (any_bad_digit(bcd_in)) begin
            // Illegal digit: skip the iterations and report straight away.
            state_d     = S_DONE;
            done_d      = 1'b1;
            digit_err_d = 1'b1;
          end else begin
            state_d = S_CONV;
            cnt_d   = CNT_W'(BIN_W);
          end
        end
      end

      S_CONV: begin
        sr_d  = step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Final iteration: the binary part of the step result is the answer.
          state_d     = S_DONE;
          done_d      = 1'b1;
          bin_out_d   = step[BIN_W-1:0];
          range_err_d = over_limit(step[BIN_W-1:0]);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bin_out_q   <= '0;
      digit_err_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bin_out_q   <= bin_out_d;
      digit_err_q <= digit_err_d;
      range_err_q <= range_err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bin_out   = bin_out_q;
  assign digit_err = digit_err_q;
  assign range_err = range_err_q;

endmodule
